regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/rv_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 66 ++++++
 rtl/regfile_sb.sv | 100 ++++++++++
 tb/tb_regfile_sb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants for the integer register file slice.
//   XLEN_DEFAULT : default data width in bits
//   NREG_DEFAULT : default architectural register count
//   REG_ZERO     : index of the hard-wired zero register
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NREG_DEFAULT = 32;
  localparam int unsigned REG_ZERO     = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one pending-producer bit per architectural register.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   rs1_addr, rs2_addr   : source addresses being looked up
//   we0/wa0, we1/wa1     : writeback ports; a write clears the target's busy bit
//   iss_en, iss_rd       : issue; marks iss_rd pending (wins over a same-cycle clear)
//   rs1_busy, rs2_busy   : source still waiting on a producer (bypassed writes count as ready)
//   dst_busy             : destination already pending, for WAW detection
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEFAULT,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_rd,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          dst_busy
);

  localparam logic [AW-1:0] Zero = AW'(REG_ZERO);

  logic [NREG-1:0] busy_q, busy_d;
  logic            wr0_ok, wr1_ok, iss_ok;
  logic            rs1_hit, rs2_hit;

  always_comb begin
    wr0_ok = we0 && (wa0 != Zero);
    wr1_ok = we1 && (wa1 != Zero);
    iss_ok = iss_en && (iss_rd != Zero);

    // Clears first, then set, so a new producer issued this cycle stays pending.
    busy_d = busy_q;
    if (wr0_ok) busy_d[wa0] = 1'b0;
    if (wr1_ok) busy_d[wa1] = 1'b0;
    if (iss_ok) busy_d[iss_rd] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_comb begin
    rs1_hit  = (wr0_ok && (wa0 == rs1_addr)) || (wr1_ok && (wa1 == rs1_addr));
    rs2_hit  = (wr0_ok && (wa0 == rs2_addr)) || (wr1_ok && (wa1 == rs2_addr));
    rs1_busy = !rst && busy_q[rs1_addr] && !rs1_hit && (rs1_addr != Zero);
    rs2_busy = !rst && busy_q[rs2_addr] && !rs2_hit && (rs2_addr != Zero);
    // Deliberately ignores same-cycle writes: the old producer is still in flight.
    dst_busy = !rst && busy_q[iss_rd] && (iss_rd != Zero);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read, two-write integer register file with write bypass and a busy scoreboard.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   rs1_addr/rs1_data    : read port 1 (combinational, bypasses same-cycle writes)
//   rs2_addr/rs2_data    : read port 2
//   rs1_busy, rs2_busy   : source has a pending producer
//   we0/wa0/wd0          : ALU writeback port
//   we1/wa1/wd1          : load writeback port (wins on same-address collision)
//   iss_en, iss_rd       : issue, marks iss_rd pending
//   dst_busy             : busy[iss_rd], for WAW detection
//   stall                : rs1_busy | rs2_busy | dst_busy
module regfile_sb
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned NREG = NREG_DEFAULT,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            stall,
  output logic            dst_busy
);

  localparam logic [AW-1:0] Zero = AW'(REG_ZERO);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr0_ok, wr1_ok;

  always_comb begin
    wr0_ok = we0 && (wa0 != Zero);
    wr1_ok = we1 && (wa1 != Zero);

    regs_d = regs_q;
    if (wr0_ok) regs_d[wa0] = wd0;
    // Port 1 applied last so it wins a same-address collision.
    if (wr1_ok) regs_d[wa1] = wd1;
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes: reset gating, zero register, then bypass with port 1 over port 0.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (wr0_ok && (wa0 == rs1_addr)) rs1_data = wd0;
    if (wr1_ok && (wa1 == rs1_addr)) rs1_data = wd1;
    if (rst || (rs1_addr == Zero)) rs1_data = '0;
  end

  always_comb begin
    rs2_data = regs_q[rs2_addr];
    if (wr0_ok && (wa0 == rs2_addr)) rs2_data = wd0;
    if (wr1_ok && (wa1 == rs2_addr)) rs2_data = wd1;
    if (rst || (rs2_addr == Zero)) rs2_data = '0;
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .we0      (we0),
    .wa0      (wa0),
    .we1      (we1),
    .wa1      (wa1),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .dst_busy (dst_busy)
  );

  assign stall = rs1_busy | rs2_busy | dst_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a reference model predicts each cycle's outputs,
// the prediction is queued when stimulus is driven and compared once outputs settle.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        stall, dst_busy;

  regfile_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .stall    (stall),
    .dst_busy (dst_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        db;
    logic        st;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'd0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return m_regs[a];
  endfunction

  function automatic logic m_src_busy(input logic [4:0] a);
    if (rst || a == 5'd0) return 1'b0;
    if ((we1 && wa1 == a) || (we0 && wa0 == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic m_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we0 && wa0 != 5'd0) begin
        m_regs[wa0] = wd0;
        m_busy[wa0] = 1'b0;
      end
      if (we1 && wa1 != 5'd0) begin
        m_regs[wa1] = wd1;
        m_busy[wa1] = 1'b0;
      end
      if (iss_en && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic e0, input logic [4:0] w0a, input logic [31:0] w0d,
                       input logic e1, input logic [4:0] w1a, input logic [31:0] w1d,
                       input logic ie, input logic [4:0] ird);
    rst = r; rs1_addr = a1; rs2_addr = a2;
    we0 = e0; wa0 = w0a; wd0 = w0d;
    we1 = e1; wa1 = w1a; wd1 = w1d;
    iss_en = ie; iss_rd = ird;
  endtask

  // Predict, queue, compare before the edge, then advance the model with the edge.
  task automatic step();
    exp_t e, g;
    e.d1 = m_read(rs1_addr);
    e.d2 = m_read(rs2_addr);
    e.b1 = m_src_busy(rs1_addr);
    e.b2 = m_src_busy(rs2_addr);
    e.db = !rst && iss_rd != 5'd0 && m_busy[iss_rd];
    e.st = e.b1 | e.b2 | e.db;
    exp_q.push_back(e);
    #2;
    g = exp_q.pop_front();
    check("rs1_data", rs1_data, g.d1);
    check("rs2_data", rs2_data, g.d2);
    check("rs1_busy", rs1_busy, g.b1);
    check("rs2_busy", rs2_busy, g.b2);
    check("dst_busy", dst_busy, g.db);
    check("stall",    stall,    g.st);
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ird);
    drive(1'b0, a1, a2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, ird);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'hxxxx_xxxx;
      m_busy[i] = 1'b0;
    end
    drive(1'b1, 5'd5, 5'd7, 1'b1, 5'd5, 32'hAAAA_5555, 1'b1, 5'd7, 32'h1, 1'b1, 5'd5);
    @(posedge clk);
    #1;
    m_update();
    // Writes and issues during reset must be ignored; outputs forced to zero.
    step();
    step();

    // Write x5 via port 0, then read it back architecturally.
    drive(1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step();
    idle(5'd5, 5'd0, 5'd0);
    step();
    check("x5_read", rs1_data, 32'hDEAD_BEEF);
    check("x5_busy", rs1_busy, 1'b0);

    // Dual write collision on x7: port 1 wins both on bypass and in storage.
    drive(1'b0, 5'd0, 5'd7, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0);
    step();
    idle(5'd0, 5'd7, 5'd0);
    step();
    check("x7_after", rs2_data, 32'h22);

    // Writes and issues to x0 have no effect.
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0);
    step();
    idle(5'd0, 5'd0, 5'd0);
    step();
    check("x0_data", rs1_data, 32'd0);
    check("x0_stall", stall, 1'b0);

    // Issue x3, observe busy, resolve by bypassed write, busy gone afterwards.
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    step();
    idle(5'd3, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd3, 5'd0, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step();
    idle(5'd3, 5'd0, 5'd0);
    step();
    check("x3_cleared", rs1_busy, 1'b0);

    // Issue and write x9 together: set wins; later WAW lookup sees busy, even with a write.
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
    step();
    idle(5'd9, 5'd0, 5'd9);
    step();
    check("x9_dst_busy", dst_busy, 1'b1);
    drive(1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 32'h123, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    step();

    // Busy x4 with data, then a single reset cycle wipes both.
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    step();
    drive(1'b1, 5'd4, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd4);
    step();
    idle(5'd4, 5'd9, 5'd4);
    step();
    check("x4_post_rst", rs1_data, 32'd0);
    check("x4_busy_rst", rs1_busy, 1'b0);
    check("stall_rst", stall, 1'b0);

    // Random traffic on a narrow address window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] hi;
      hi = (n % 2 == 0) ? 5'd7 : 5'd31;
      drive(($urandom_range(0, 39) == 0),
            5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, hi)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, hi)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, hi)));
      step();
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
